// File: rtl/zeroheti_dbg_hart_ctrl.sv
// ============================================================================
// Module   : zeroheti_dbg_hart_ctrl
// Brief    : Multi-hart debug side-band controller: stretches ndmreset, gates
//            halt requests around reset and derives per-hart unavailable
//            status. Macro ZEROHETI_DBG_TIMEOUT_EN adds halt-ack timeouts.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module zeroheti_dbg_hart_ctrl #(
    parameter int NR_HARTS     = 1,
    parameter int RESET_CYCLES = 16,
    parameter int REQ_TIMEOUT  = 1024
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                dm_ndmreset_i,
    input  logic [NR_HARTS-1:0] dm_debug_req_i,
    input  logic [NR_HARTS-1:0] hart_halted_i,
    output logic                ndmreset_o,
    output logic [NR_HARTS-1:0] debug_req_o,
    output logic [NR_HARTS-1:0] unavailable_o,
    output logic                busy_o
);

    localparam int              c_RC_W    = $clog2(RESET_CYCLES + 1);
    localparam logic [c_RC_W-1:0] c_RC_LOAD = c_RC_W'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ASSERT = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_RC_W-1:0]   r_rst_cnt;
    logic                r_ndmreset;
    logic                r_busy;
    logic [NR_HARTS-1:0] r_dbg_req;
    logic [NR_HARTS-1:0] w_unavail;
    logic                w_idle_nxt;

    // FSM will be in IDLE after this edge: lets the outputs switch in step with it.
    assign w_idle_nxt = ((r_state == S_IDLE) ||
                         ((r_state == S_SETTLE) && (r_rst_cnt == '0))) && !dm_ndmreset_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_rst_cnt  <= '0;
            r_ndmreset <= 1'b0;
            r_busy     <= 1'b0;
            r_dbg_req  <= '0;
        end else begin
            r_busy    <= !w_idle_nxt;
            r_dbg_req <= ((r_state == S_IDLE) && !dm_ndmreset_i) ? dm_debug_req_i : '0;
            case (r_state)
                S_IDLE: begin
                    if (dm_ndmreset_i) begin
                        r_state    <= S_ASSERT;
                        r_rst_cnt  <= c_RC_LOAD;
                        r_ndmreset <= 1'b1;
                    end
                end
                S_ASSERT: begin
                    if (r_rst_cnt != '0) begin
                        r_rst_cnt <= r_rst_cnt - c_RC_W'(1);
                    end else if (!dm_ndmreset_i) begin
                        r_state    <= S_SETTLE;
                        r_rst_cnt  <= c_RC_LOAD;
                        r_ndmreset <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (dm_ndmreset_i) begin
                        r_state    <= S_ASSERT;
                        r_rst_cnt  <= c_RC_LOAD;
                        r_ndmreset <= 1'b1;
                    end else if (r_rst_cnt != '0) begin
                        r_rst_cnt <= r_rst_cnt - c_RC_W'(1);
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_ndmreset <= 1'b0;
                end
            endcase
        end
    end

`ifdef ZEROHETI_DBG_TIMEOUT_EN
    localparam int              c_TO_W   = $clog2(REQ_TIMEOUT + 1);
    localparam logic [c_TO_W-1:0] c_TO_MAX = c_TO_W'(REQ_TIMEOUT);

    for (genvar h = 0; h < NR_HARTS; h++) begin : g_timeout
        logic [c_TO_W-1:0] r_to_cnt;
        logic              r_unavail;

        // Clear has priority over counting; the flag is sticky until cleared.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_to_cnt  <= '0;
                r_unavail <= 1'b0;
            end else if (!w_idle_nxt) begin
                r_to_cnt  <= '0;
                r_unavail <= 1'b1;
            end else if ((r_state != S_IDLE) || hart_halted_i[h] || !dm_debug_req_i[h]) begin
                r_to_cnt  <= '0;
                r_unavail <= 1'b0;
            end else begin
                if (r_dbg_req[h] && (r_to_cnt != c_TO_MAX)) begin
                    r_to_cnt <= r_to_cnt + c_TO_W'(1);
                end
                if (r_to_cnt == c_TO_MAX) begin
                    r_unavail <= 1'b1;
                end
            end
        end

        assign w_unavail[h] = r_unavail;
    end : g_timeout
`else
    logic [NR_HARTS-1:0] r_unavail;
    logic                w_unused_halted;
    logic [31:0]         w_unused_timeout;

    assign w_unused_halted  = ^hart_halted_i;
    assign w_unused_timeout = REQ_TIMEOUT;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_unavail <= '0;
        end else begin
            r_unavail <= {NR_HARTS{!w_idle_nxt}};
        end
    end

    assign w_unavail = r_unavail;
`endif

    assign ndmreset_o    = r_ndmreset;
    assign debug_req_o   = r_dbg_req;
    assign unavailable_o = w_unavail;
    assign busy_o        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_zeroheti_dbg_hart_ctrl.sv
// ============================================================================
// Module   : tb_zeroheti_dbg_hart_ctrl
// Brief    : Directed vector bench for zeroheti_dbg_hart_ctrl (2 harts).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_zeroheti_dbg_hart_ctrl;

    localparam int c_NR_HARTS = 2;
    localparam int c_RC       = 16;
    localparam int c_TO       = 8;

    logic       clk_i;
    logic       rst_ni;
    logic       dm_ndmreset_i;
    logic [1:0] dm_debug_req_i;
    logic [1:0] hart_halted_i;
    logic       ndmreset_o;
    logic [1:0] debug_req_o;
    logic [1:0] unavailable_o;
    logic       busy_o;

    int n_checks;
    int n_errors;

    zeroheti_dbg_hart_ctrl #(
        .NR_HARTS     (c_NR_HARTS),
        .RESET_CYCLES (c_RC),
        .REQ_TIMEOUT  (c_TO)
    ) u_dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .dm_ndmreset_i  (dm_ndmreset_i),
        .dm_debug_req_i (dm_debug_req_i),
        .hart_halted_i  (hart_halted_i),
        .ndmreset_o     (ndmreset_o),
        .debug_req_o    (debug_req_o),
        .unavailable_o  (unavailable_o),
        .busy_o         (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       ndm;
        logic [1:0] req;
        logic [1:0] halt;
        logic       exp_ndm;
        logic [1:0] exp_dbg;
        logic [1:0] exp_unav;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all(input string name, input logic e_ndm, input logic [1:0] e_dbg,
                             input logic [1:0] e_unav, input logic e_busy);
        check({name, ".ndmreset"}, 32'(ndmreset_o), 32'(e_ndm));
        check({name, ".debug_req"}, 32'(debug_req_o), 32'(e_dbg));
        check({name, ".unavail"}, 32'(unavailable_o), 32'(e_unav));
        check({name, ".busy"}, 32'(busy_o), 32'(e_busy));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        vecs[0] = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[1] = '{1'b0, 2'b01, 2'b01, 1'b0, 2'b01, 2'b00, 1'b0};
        vecs[2] = '{1'b0, 2'b10, 2'b10, 1'b0, 2'b10, 2'b00, 1'b0};
        vecs[3] = '{1'b0, 2'b11, 2'b11, 1'b0, 2'b11, 2'b00, 1'b0};
        vecs[4] = '{1'b0, 2'b01, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0};
        vecs[5] = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0};

        rst_ni         = 1'b0;
        dm_ndmreset_i  = 1'b0;
        dm_debug_req_i = 2'b00;
        hart_halted_i  = 2'b00;
        step();
        step();
        check_all("reset", 1'b0, 2'b00, 2'b00, 1'b0);
        #2 rst_ni = 1'b1;
        step();
        check_all("post_reset", 1'b0, 2'b00, 2'b00, 1'b0);

        // Single-cycle gating vectors in IDLE
        for (int i = 0; i < 6; i++) begin
            dm_ndmreset_i  = vecs[i].ndm;
            dm_debug_req_i = vecs[i].req;
            hart_halted_i  = vecs[i].halt;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].exp_ndm, vecs[i].exp_dbg,
                      vecs[i].exp_unav, vecs[i].exp_busy);
        end

        // 1-cycle ndmreset request with halt requests held throughout
        dm_ndmreset_i  = 1'b1;
        dm_debug_req_i = 2'b11;
        hart_halted_i  = 2'b11;
        step();
        dm_ndmreset_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            check_all($sformatf("pulse%0d", i), (i < 16), (i >= 33) ? 2'b11 : 2'b00,
                      (i < 32) ? 2'b11 : 2'b00, (i < 32));
            step();
        end

        // Extended request, then re-trigger in SETTLE cycle 5
        dm_debug_req_i = 2'b00;
        hart_halted_i  = 2'b00;
        dm_ndmreset_i  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            check($sformatf("ext_high%0d", i), 32'(ndmreset_o), 32'd1);
        end
        dm_ndmreset_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("settle_ndm%0d", i), 32'(ndmreset_o), 32'd0);
            check($sformatf("settle_busy%0d", i), 32'(busy_o), 32'd1);
        end
        dm_ndmreset_i = 1'b1;
        step();
        dm_ndmreset_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("retrig_high%0d", i), 32'(ndmreset_o), 32'd1);
            step();
        end
        check_all("retrig_settle", 1'b0, 2'b00, 2'b11, 1'b1);
        for (int i = 0; i < 15; i++) step();
        check("retrig_busy_last", 32'(busy_o), 32'd1);
        step();
        check_all("retrig_idle", 1'b0, 2'b00, 2'b00, 1'b0);

`ifdef ZEROHETI_DBG_TIMEOUT_EN
        // Hart0 timeout: flag after c_TO request cycles plus one
        dm_debug_req_i = 2'b01;
        step();
        check("to_dbg", 32'(debug_req_o), 32'h1);
        for (int i = 0; i < c_TO; i++) begin
            step();
            check($sformatf("to_pre%0d", i), 32'(unavailable_o), 32'h0);
        end
        step();
        check("to_flag", 32'(unavailable_o), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("to_sticky%0d", i), 32'(unavailable_o), 32'h1);
        end
        hart_halted_i = 2'b01;
        step();
        check("to_clear", 32'(unavailable_o), 32'h0);
        dm_debug_req_i = 2'b00;
        hart_halted_i  = 2'b00;
        step();

        // Hart1 acknowledged 3 cycles after its request appears
        dm_debug_req_i = 2'b10;
        step();
        step();
        step();
        hart_halted_i = 2'b10;
        for (int i = 0; i < 12; i++) begin
            step();
            check($sformatf("ack%0d", i), 32'(unavailable_o), 32'h0);
        end
        dm_debug_req_i = 2'b00;
        hart_halted_i  = 2'b00;
        step();

        // Halt arrives on the same edge the counter is saturated: clear wins
        dm_debug_req_i = 2'b10;
        step();
        for (int i = 0; i < c_TO; i++) step();
        hart_halted_i = 2'b10;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("sat_halt%0d", i), 32'(unavailable_o), 32'h0);
        end
`else
        dm_debug_req_i = 2'b01;
        step();
        for (int i = 0; i < 2 * c_TO + 4; i++) begin
            step();
            check($sformatf("noto_unav%0d", i), 32'(unavailable_o), 32'h0);
            check($sformatf("noto_dbg%0d", i), 32'(debug_req_o), 32'h1);
        end
`endif

        // Asynchronous reset in the middle of ASSERT
        dm_debug_req_i = 2'b11;
        hart_halted_i  = 2'b11;
        dm_ndmreset_i  = 1'b1;
        step();
        dm_ndmreset_i = 1'b0;
        step();
        step();
        check_all("pre_async", 1'b1, 2'b00, 2'b11, 1'b1);
        #2 rst_ni = 1'b0;
        #1;
        check_all("async", 1'b0, 2'b00, 2'b00, 1'b0);
        #2 rst_ni = 1'b1;
        step();
        check_all("async_rel", 1'b0, 2'b11, 2'b00, 1'b0);
        step();
        check_all("async_idle", 1'b0, 2'b11, 2'b00, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
